// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router output-side control.
// Address, port count and per-port read-timeout state definitions.
package router_pkg;

  typedef logic [1:0] addr_t;

  localparam addr_t ADDR_NONE       = 2'b11;
  localparam int    NUM_PORTS       = 3;
  localparam int    TIMEOUT_DEFAULT = 30;

  typedef enum logic {TO_IDLE, TO_COUNT} to_state_t;

  function automatic logic [NUM_PORTS-1:0] addr_onehot(input addr_t a);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    unique case (1'b1)
      (a == 2'd0): oh = 3'b001;
      (a == 2'd1): oh = 3'b010;
      (a == 2'd2): oh = 3'b100;
      default:     oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_timeout_ctr.sv
// Per-port read timeout: a registered one-cycle soft reset fires after
// TIMEOUT_CYCLES consecutive cycles of valid data with no read.
module router_timeout_ctr
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd_en,
  output logic soft_rst
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  to_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_soft_rst;
  logic             w_stall;

  assign w_stall  = vld & ~rd_en;
  assign soft_rst = r_soft_rst;

  // The pulse cycle itself is not counted; counting resumes after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= TO_IDLE;
      r_cnt      <= '0;
      r_soft_rst <= 1'b0;
    end else begin
      r_soft_rst <= 1'b0;
      unique case (r_state)
        TO_IDLE: begin
          if (w_stall && !r_soft_rst) begin
            r_state <= TO_COUNT;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        TO_COUNT: begin
          if (!w_stall) begin
            r_state <= TO_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST) begin
            r_state    <= TO_IDLE;
            r_cnt      <= '0;
            r_soft_rst <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= TO_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/router_sync_ctrl.sv
// Router output-side synchroniser: address latch, write steering, full mux,
// valid outputs and per-port read timeouts. Option: ROUTER_SYNC_STATS_EN.
module router_sync_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detect_addr,
  input  logic [1:0] din,
  input  logic       wr_en_req,
  input  logic       rd_en_0,
  input  logic       rd_en_1,
  input  logic       rd_en_2,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       fifo_full_0,
  input  logic       fifo_full_1,
  input  logic       fifo_full_2,
  output logic [2:0] wr_en,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_rst_0,
  output logic       soft_rst_1,
  output logic       soft_rst_2
`ifdef ROUTER_SYNC_STATS_EN
  ,
  output logic [7:0] soft_rst_cnt
`endif
);

  addr_t                r_addr;
  logic [NUM_PORTS-1:0] w_vld;
  logic [NUM_PORTS-1:0] w_rd;
  logic [NUM_PORTS-1:0] w_srst;

  assign w_vld = ~{fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_rd  = {rd_en_2, rd_en_1, rd_en_0};

  assign vld_out_0  = w_vld[0];
  assign vld_out_1  = w_vld[1];
  assign vld_out_2  = w_vld[2];
  assign soft_rst_0 = w_srst[0];
  assign soft_rst_1 = w_srst[1];
  assign soft_rst_2 = w_srst[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= ADDR_NONE;
    end else if (detect_addr) begin
      r_addr <= din;
    end
  end

  // A FIFO being soft-reset must not accept a write in the same cycle.
  always_comb begin
    wr_en = '0;
    if (wr_en_req) begin
      wr_en = addr_onehot(r_addr) & ~w_srst;
    end
  end

  always_comb begin
    fifo_full = 1'b0;
    unique case (1'b1)
      (r_addr == 2'd0): fifo_full = fifo_full_0;
      (r_addr == 2'd1): fifo_full = fifo_full_1;
      (r_addr == 2'd2): fifo_full = fifo_full_2;
      default:          fifo_full = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_to
    router_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_to (
      .clk     (clk),
      .rst     (rst),
      .vld     (w_vld[gi]),
      .rd_en   (w_rd[gi]),
      .soft_rst(w_srst[gi])
    );
  end

`ifdef ROUTER_SYNC_STATS_EN
  logic [7:0] r_stat;
  logic [1:0] w_npulse;
  logic [8:0] w_sum;

  assign w_npulse = 2'(w_srst[0]) + 2'(w_srst[1]) + 2'(w_srst[2]);
  assign w_sum    = {1'b0, r_stat} + 9'(w_npulse);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat <= '0;
    end else begin
      r_stat <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end

  assign soft_rst_cnt = r_stat;
`endif

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Scoreboarded random/directed bench for router_sync_ctrl against a
// cycle-level behavioural model of address steering and read timeouts.
module tb_router_sync_ctrl;

  localparam int T = 30;

  typedef struct {
    logic [2:0] wr_en;
    logic       full;
    logic [2:0] vld;
    logic [2:0] srst;
    int         cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       detect_addr = 1'b0;
  logic [1:0] din = 2'd0;
  logic       wr_en_req = 1'b0;
  logic [2:0] rd = 3'b000;
  logic [2:0] emp = 3'b111;
  logic [2:0] fu = 3'b000;
  logic [2:0] wr_en;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;
  logic [7:0] cnt_out;
`ifdef ROUTER_SYNC_STATS_EN
  logic [7:0] soft_rst_cnt;
  assign cnt_out = soft_rst_cnt;
`else
  assign cnt_out = 8'd0;
`endif

  int total = 0;
  int bad   = 0;
  int pulses_seen = 0;
  exp_t q[$];

  // Model state
  int m_addr = 3;
  int m_run[3];
  int m_pulse[3];
  int m_cnt = 0;

  always #5 clk = ~clk;

  router_sync_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .detect_addr(detect_addr), .din(din),
    .wr_en_req(wr_en_req),
    .rd_en_0(rd[0]), .rd_en_1(rd[1]), .rd_en_2(rd[2]),
    .fifo_empty_0(emp[0]), .fifo_empty_1(emp[1]), .fifo_empty_2(emp[2]),
    .fifo_full_0(fu[0]), .fifo_full_1(fu[1]), .fifo_full_2(fu[2]),
    .wr_en(wr_en), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1),
    .soft_rst_2(soft_rst_2)
`ifdef ROUTER_SYNC_STATS_EN
    , .soft_rst_cnt(soft_rst_cnt)
`endif
  );

  task automatic model_reset();
    m_addr = 3;
    m_cnt  = 0;
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0;
      m_pulse[i] = 0;
    end
  endtask

  task automatic step(input logic rn, input logic d, input logic [1:0] a,
                      input logic w, input logic [2:0] r,
                      input logic [2:0] e, input logic [2:0] f);
    exp_t x;
    int np;
    @(posedge clk);
    #1;
    rst = rn; detect_addr = d; din = a; wr_en_req = w;
    rd = r; emp = e; fu = f;
    #1;
    if (!rn) model_reset();
    x.vld = ~e;
    x.wr_en = 3'b000;
    x.full = 1'b0;
    if (m_addr != 3) begin
      x.full = f[m_addr];
      if (w && !m_pulse[m_addr]) x.wr_en[m_addr] = 1'b1;
    end
    for (int i = 0; i < 3; i++) x.srst[i] = (m_pulse[i] != 0);
`ifdef ROUTER_SYNC_STATS_EN
    x.cnt = m_cnt;
`else
    x.cnt = 0;
`endif
    q.push_back(x);
    if (rn) begin
      if (d) m_addr = int'(a);
      np = 0;
      for (int i = 0; i < 3; i++) begin
        if (m_pulse[i] != 0) begin
          np++;
          m_pulse[i] = 0;
          m_run[i] = 0;
        end else if (!e[i] && !r[i]) begin
          m_run[i]++;
          if (m_run[i] == T) begin
            m_pulse[i] = 1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_cnt = (m_cnt + np > 255) ? 255 : m_cnt + np;
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("wr_en", int'(wr_en), int'(x.wr_en));
      chk("fifo_full", int'(fifo_full), int'(x.full));
      chk("vld_out", int'({vld_out_2, vld_out_1, vld_out_0}), int'(x.vld));
      chk("soft_rst", int'({soft_rst_2, soft_rst_1, soft_rst_0}),
          int'(x.srst));
      chk("soft_rst_cnt", int'(cnt_out), x.cnt);
      if (soft_rst_0 | soft_rst_1 | soft_rst_2) pulses_seen++;
    end
  end

  initial begin
    model_reset();
    // reset state
    repeat (3) step(0, 0, 0, 1, 3'b000, 3'b000, 3'b111);
    // address 1 steering and full tracking
    step(1, 1, 2'd1, 0, 3'b111, 3'b111, 3'b000);
    step(1, 0, 2'd0, 1, 3'b111, 3'b111, 3'b000);
    step(1, 0, 2'd0, 1, 3'b111, 3'b111, 3'b010);
    step(1, 0, 2'd0, 1, 3'b111, 3'b111, 3'b101);
    // detect with write: old address used that cycle
    step(1, 1, 2'd0, 1, 3'b111, 3'b111, 3'b011);
    // no destination
    step(1, 1, 2'd3, 1, 3'b111, 3'b111, 3'b111);
    repeat (2) step(1, 0, 2'd0, 1, 3'b111, 3'b111, 3'b111);
    // port 0 timeout, two consecutive pulses
    repeat (70) step(1, 0, 2'd0, 0, 3'b000, 3'b110, 3'b000);
    step(1, 0, 2'd0, 0, 3'b111, 3'b111, 3'b000);
    // read on the final cycle suppresses the pulse
    repeat (29) step(1, 0, 2'd0, 0, 3'b000, 3'b110, 3'b000);
    step(1, 0, 2'd0, 0, 3'b001, 3'b110, 3'b000);
    repeat (32) step(1, 0, 2'd0, 0, 3'b000, 3'b110, 3'b000);
    step(1, 0, 2'd0, 0, 3'b111, 3'b111, 3'b000);
    // ports 0 and 2 together, write to 2 masked during pulse
    step(1, 1, 2'd2, 0, 3'b111, 3'b111, 3'b000);
    repeat (33) step(1, 0, 2'd0, 1, 3'b000, 3'b010, 3'b100);
    // reset mid-count, then full period needed
    step(1, 0, 2'd0, 0, 3'b111, 3'b111, 3'b000);
    repeat (20) step(1, 0, 2'd0, 0, 3'b000, 3'b110, 3'b000);
    step(0, 0, 2'd0, 0, 3'b000, 3'b110, 3'b000);
    repeat (35) step(1, 0, 2'd0, 0, 3'b000, 3'b110, 3'b000);
    // random traffic, mostly unread so timeouts occur
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] r, e, f;
      logic [1:0] a;
      for (int i = 0; i < 3; i++) begin
        r[i] = ($urandom_range(0, 15) == 0);
        e[i] = ($urandom_range(0, 19) == 0);
        f[i] = $urandom_range(0, 1) != 0;
      end
      a = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 999) != 0), ($urandom_range(0, 7) == 0), a,
           $urandom_range(0, 1) != 0, r, e, f);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    total++;
    if (pulses_seen < 4) begin
      bad++;
      $display("FAIL pulse_activity: got %0d expected >=4", pulses_seen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_sync_ctrl.md
Name: router_sync_ctrl

Overview:
Output-side synchroniser and scheduler for the 1x3 router. It latches the destination address when the FSM is in address decode, and steers the FSM's single write request to one of three FIFO write enables. It multiplexes the addressed FIFO's full flag back to the FSM and drives per-port valid outputs. It also runs a per-port read-timeout that issues the soft resets consumed by the FSM and FIFOs.

Parameters:
TIMEOUT_CYCLES, 30, consecutive valid-but-unread cycles before a port's soft reset fires (legal range 2..255)
CNT_W, 8, width of each timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
detect_addr  in  1  FSM in address-decode state
din  in  2  header address bits (0,1,2 valid; 3 = no destination)
wr_en_req  in  1  FSM write request
rd_en_0 / rd_en_1 / rd_en_2  in  1 each  downstream read enable per port
fifo_empty_0 / fifo_empty_1 / fifo_empty_2  in  1 each  FIFO empty flags
fifo_full_0 / fifo_full_1 / fifo_full_2  in  1 each  FIFO full flags
wr_en  out  3  one-hot FIFO write enable, bit i = FIFO i
fifo_full  out  1  full flag of the addressed FIFO, to the FSM
vld_out_0 / vld_out_1 / vld_out_2  out  1 each  port has data
soft_rst_0 / soft_rst_1 / soft_rst_2  out  1 each  registered one-cycle soft reset pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - addr_reg = ADDR_NONE (2'b11); all timeout counters = 0; soft_rst_* = 0.
  - Hence wr_en = 3'b000 and fifo_full = 0.
  - vld_out_* follows the FIFO flags combinationally.
- Address capture:
  - On a posedge with detect_addr=1, addr_reg <= din, including din=3.
  - Otherwise addr_reg holds.
- wr_en (combinational, zero latency):
  - Equals onehot(addr_reg) when wr_en_req=1 and addr_reg != 3, else 0.
  - Bit i is additionally masked to 0 while soft_rst_i=1.
- fifo_full (combinational):
  - fifo_full_{addr_reg} when addr_reg is 0..2.
  - 0 when addr_reg = 3.
- vld_out_i = ~fifo_empty_i (combinational).
- Per-port timeout, identical for i = 0..2:
  - State machine has two states.
  - IDLE: counter = 0. Go to COUNT when vld_out_i=1 and rd_en_i=0.
  - COUNT:
    - Counter increments each cycle with vld_out_i=1 and rd_en_i=0.
    - rd_en_i=1 or vld_out_i=0 returns to IDLE with counter = 0.
    - When the counter reaches TIMEOUT_CYCLES-1 and the condition still holds, soft_rst_i <= 1 for exactly one cycle, then return to IDLE with counter = 0.
  - Net timing: soft_rst_i rises on the clock edge that ends the TIMEOUT_CYCLES-th consecutive unread valid cycle.
  - A read in that same final cycle suppresses the pulse.
  - During the pulse cycle the counter is held at 0; counting restarts the next cycle if the condition persists.
- Simultaneous events:
  - Ports time out independently; several soft_rst_* may pulse in the same cycle.
  - detect_addr together with wr_en_req: wr_en uses the old addr_reg for that cycle.
- Reset mid-operation: all state clears immediately, and no pending soft_rst pulse is emitted after rst releases.

Optional Feature:
ROUTER_SYNC_STATS_EN
- Defined: adds output soft_rst_cnt [7:0]. It counts soft_rst pulses across all ports and saturates at 8'hFF. When several ports pulse in one cycle it adds their number (saturating). It resets to 0 asynchronously.
- Undefined: no port and no logic.

Decomposition:
- Package router_pkg:
  - typedef logic [1:0] addr_t
  - ADDR_NONE = 2'b11
  - NUM_PORTS = 3
  - TIMEOUT_DEFAULT = 30
  - typedef enum {TO_IDLE, TO_COUNT} to_state_t
- Sub-module router_timeout_ctr: one instance per port. Inputs clk, rst, vld, rd_en; output soft_rst; parameters TIMEOUT_CYCLES and CNT_W.

Test Plan:
- Reset then detect_addr=1, din=1, then wr_en_req=1 -> wr_en=3'b010 in the same cycle; fifo_full tracks fifo_full_1.
- detect_addr=1 with din=3, then wr_en_req=1 -> wr_en=3'b000 and fifo_full=0, even with all fifo_full_*=1.
- fifo_empty_0=0, rd_en_0=0 held 30 cycles -> soft_rst_0=1 for exactly one cycle at the edge after cycle 30; the next pulse comes 31 cycles after that.
- Same as above, but rd_en_0=1 on cycle 30 -> no pulse; the counter restarts from 0.
- Ports 0 and 2 valid and unread from the same cycle -> soft_rst_0 and soft_rst_2 pulse together. With addr_reg=2 and wr_en_req=1, wr_en=3'b000 during the pulse. With ROUTER_SYNC_STATS_EN defined, soft_rst_cnt increments by 2.
- rst asserted at counter=20 -> counter and soft_rst clear asynchronously; after release, a full 30 cycles are needed before a pulse.
